seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised sequential shift-add multiplier: next generation of the team's 4-bit start/product multiplier, generalised to WIDTH-bit operands with run-time signed/unsigned mode, a busy/done handshake and back-to-back operation. It is an iterative arithmetic unit for datapaths where a single-cycle array multiplier is too large. It produces one product every WIDTH+1 cycles.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- SIGNED_EN, 1, when 1 signed_mode is honoured; when 0 all operations are unsigned.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- multiplier  in  WIDTH  operand A; sampled with start.
- multiplicand  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product is valid while done is high.
- product  out  2*WIDTH  result; holds until the next completion or reset.

## Operation
- FSM states:
  - IDLE: start=1 goes to RUN.
  - RUN: lasts exactly WIDTH cycles, then goes to DONE.
  - DONE: lasts one cycle. start=1 goes to RUN; otherwise goes to IDLE.
- Capture on accepted start:
  - The operands and effective sign mode are latched. Effective sign mode = signed_mode & SIGNED_EN.
  - In signed mode, each operand is replaced by its magnitude, and res_neg = A[MSB] ^ B[MSB] is recorded.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held unsigned in WIDTH bits.
  - The 2*WIDTH accumulator and the iteration counter are cleared.
- Each RUN cycle:
  - If the multiplier LSB is 1, add the multiplicand, aligned at the current bit position, to the accumulator.
  - Shift the multiplier right by one.
  - Increment the counter.
  - All adds are 2*WIDTH wide. The magnitude product is at most 2^(2*WIDTH-2) signed / (2^WIDTH-1)^2 unsigned, so it never overflows.
- Leaving RUN:
  - product = res_neg ? -acc : acc, computed modulo 2^(2*WIDTH).
  - A zero product is never negated to a nonzero value.
- Input changes during RUN have no effect on the operation in flight.
- start while in RUN is ignored. It is not queued.

## Timing
- Reset values (rst low, asynchronous): state=IDLE, busy=0, done=0, product=0, accumulator and counter=0.
- Reset mid-RUN aborts the operation immediately. No done pulse is produced.
- rst deassertion is synchronised externally. The first start is accepted at the first rising edge with rst high.
- Latency, with start accepted at edge 0:
  - busy=1 after edge 0.
  - Iterations occur at edges 1..WIDTH.
  - product is updated and done=1 after edge WIDTH. busy=0 from the same edge.
  - done=0 after edge WIDTH+1.
- Back-to-back: start=1 during the DONE cycle is accepted at edge WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
  - done pulses are never adjacent.
- done and busy are never both high.

## Structure
- Package seq_mult_pkg holds:
  - typedef state_t, encoded IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - The default WIDTH constant.
- One sub-module, seq_mult_dp, holds:
  - Operand magnitude conversion, shift registers, the accumulator, the counter and the final sign correction.
  - It is driven by load/step/finish strobes from the FSM in seq_mult.
- The counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=4, unsigned 6 x 3 -> done exactly 4 edges after start, product=8'd18, busy high for 4 cycles.
- WIDTH=4, unsigned 15 x 15 -> 225; 0 x 12 -> 0; 15 x 1 and 1 x 15 -> 15.
- WIDTH=4, signed: -8 x -8 -> 8'h40; -3 x 5 -> 8'hF1; 7 x -1 -> 8'hF9; SIGNED_EN=0 with signed_mode=1, 15 x 15 -> 225.
- Operands changed and start pulsed mid-RUN -> ignored: original product delivered, exactly one done pulse.
- rst low at RUN cycle 2 -> busy=0, done=0, product=0 immediately; next start (3 x 3) -> 9 on schedule.
- WIDTH=8, back-to-back: 255 x 255 then start held in DONE with 2 x 3 -> 16'd65025, then 16'd6 nine edges later; done pulses separated by 8 low cycles.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
//
// Shared types and constants for the sequential shift-add multiplier.
//   state_t        : control FSM encoding used by seq_mult.
//   DEFAULT_WIDTH  : default operand width in bits.
//   cnt_width()    : width of the iteration counter for a given operand width.
// ---------------------------------------------------------------------------
package seq_mult_pkg;

    // Control states. RUN lasts WIDTH cycles, DONE exactly one.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : seq_mult_pkg

// File: rtl/seq_mult_dp.sv
// ---------------------------------------------------------------------------
// seq_mult_dp
//
// Datapath of the sequential shift-add multiplier. Converts operands to
// magnitudes on load, performs one shift-add iteration per step, and writes
// the sign-corrected product on finish.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load           capture operands, clear accumulator and counter
//   step           perform one shift-add iteration
//   finish         write product from this cycle's accumulator result
//                  (asserted together with the final step)
//   signed_mode    two's-complement operands (qualified by SIGNED_EN)
//   multiplier     operand A
//   multiplicand   operand B
//   last           counter shows the final iteration is in progress
//   product        2*WIDTH result, held until the next finish or reset
// ---------------------------------------------------------------------------
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    // State registers
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             neg_q,    neg_d;
    logic [PW-1:0]    product_q, product_d;

    // Operand conditioning
    logic             eff_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Iteration arithmetic
    logic [PW-1:0]    add_term;
    logic [PW-1:0]    acc_sum;

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exactly the
    // right value when the result is read as unsigned WIDTH bits.
    always_comb begin
        eff_signed = signed_mode & SIGNED_EN;
        a_neg      = eff_signed & multiplier[WIDTH-1];
        b_neg      = eff_signed & multiplicand[WIDTH-1];
        a_mag      = a_neg ? (~multiplier + WIDTH'(1))   : multiplier;
        b_mag      = b_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
    end

    // The multiplicand register is pre-shifted each step, so it is always
    // aligned with the multiplier bit currently sitting in mplier_q[0].
    always_comb begin
        add_term = mplier_q[0] ? mcand_q : '0;
        acc_sum  = acc_q + add_term;
    end

    // NOTE: every signal written here receives a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        if (load) begin
            mplier_d = a_mag;
            mcand_d  = {{WIDTH{1'b0}}, b_mag};
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = a_neg ^ b_neg;
        end else if (step) begin
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            acc_d    = acc_sum;
            cnt_d    = cnt_q + CW'(1);
        end

        // Uses acc_sum so the final iteration and the sign correction land on
        // the same edge. Two's-complement negation of zero stays zero.
        if (finish) begin
            product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mplier_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign product = product_q;

endmodule : seq_mult_dp

// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult
//
// Parametrised sequential shift-add multiplier with optional signed mode.
// One product every WIDTH+1 cycles; a start seen in the DONE cycle chains
// the next operation without an idle gap.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          request, accepted in IDLE or DONE only
//   signed_mode    two's-complement operands, sampled with start
//   multiplier     operand A, sampled with start
//   multiplicand   operand B, sampled with start
//   busy           high while an operation is iterating
//   done           one-cycle pulse, product valid while high
//   product        result, held until the next completion or reset
// ---------------------------------------------------------------------------
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t state_q, state_d;

    logic load;
    logic step;
    logic finish;
    logic last;

    // Next-state and datapath strobes. start is only looked at in IDLE and
    // DONE, which is what makes a request during RUN a no-op.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded straight from the state register: mutually exclusive by
    // construction and free of combinational paths from the inputs.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    seq_mult_dp #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .finish       (finish),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .last         (last),
        .product      (product)
    );

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult
//
// Self-checking bench for seq_mult. Three instances: WIDTH=4 signed-capable,
// WIDTH=4 with signed mode disabled, and WIDTH=8 for back-to-back traffic.
// Expected products are pushed to per-instance queues when stimulus is
// driven and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=4, SIGNED_EN=1
    logic       a4_start, a4_sm, a4_busy, a4_done;
    logic [3:0] a4_a, a4_b;
    logic [7:0] a4_prod;

    // WIDTH=4, SIGNED_EN=0
    logic       u4_start, u4_sm, u4_busy, u4_done;
    logic [3:0] u4_a, u4_b;
    logic [7:0] u4_prod;

    // WIDTH=8, SIGNED_EN=1
    logic       w8_start, w8_sm, w8_busy, w8_done;
    logic [7:0] w8_a, w8_b;
    logic [15:0] w8_prod;

    seq_mult #(.WIDTH(4), .SIGNED_EN(1'b1)) dut_a4 (
        .clk(clk), .rst(rst), .start(a4_start), .signed_mode(a4_sm),
        .multiplier(a4_a), .multiplicand(a4_b),
        .busy(a4_busy), .done(a4_done), .product(a4_prod)
    );

    seq_mult #(.WIDTH(4), .SIGNED_EN(1'b0)) dut_u4 (
        .clk(clk), .rst(rst), .start(u4_start), .signed_mode(u4_sm),
        .multiplier(u4_a), .multiplicand(u4_b),
        .busy(u4_busy), .done(u4_done), .product(u4_prod)
    );

    seq_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_w8 (
        .clk(clk), .rst(rst), .start(w8_start), .signed_mode(w8_sm),
        .multiplier(w8_a), .multiplicand(w8_b),
        .busy(w8_busy), .done(w8_done), .product(w8_prod)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  q_a4[$];
    logic [7:0]  q_u4[$];
    logic [15:0] q_w8[$];

    // Reference product, straight multiplication of extended operands.
    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b,
                                          input logic sm);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        if (sm) begin
            sa = {{4{a[3]}}, a};
            sb = {{4{b[3]}}, b};
        end else begin
            sa = {4'b0000, a};
            sb = {4'b0000, b};
        end
        return 8'(sa * sb);
    endfunction

    // done and busy must never overlap on any instance.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((a4_busy && a4_done) !== 1'b0 || (u4_busy && u4_done) !== 1'b0 ||
                (w8_busy && w8_done) !== 1'b0) begin
                errors++;
                $display("FAIL busy_done_overlap: a4=%b%b u4=%b%b w8=%b%b required no overlap",
                         a4_busy, a4_done, u4_busy, u4_done, w8_busy, w8_done);
            end
        end
    end

    // One WIDTH=4 operation with latency, busy-length and product checks.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [7:0] expected, input string name);
        int n;
        int busy_cycles;
        logic [7:0] exp_v;
        @(negedge clk);
        a4_a = a; a4_b = b; a4_sm = sm; a4_start = 1'b1;
        q_a4.push_back(expected);
        @(negedge clk);
        a4_start = 1'b0;
        a4_a = 4'($urandom);
        a4_b = 4'($urandom);
        a4_sm = 1'($urandom);
        n = 0;
        busy_cycles = 0;
        while (a4_done !== 1'b1 && n < 20) begin
            if (a4_busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (a4_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
            void'(q_a4.pop_front());
            return;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges, required 4", name, n);
        end
        checks++;
        if (busy_cycles !== 4) begin
            errors++;
            $display("FAIL %s_busy_len: busy for %0d cycles, required 4", name, busy_cycles);
        end
        exp_v = q_a4.pop_front();
        checks++;
        if (a4_prod !== exp_v) begin
            errors++;
            $display("FAIL %s_product: got 0x%02h, required 0x%02h", name, a4_prod, exp_v);
        end
        @(negedge clk);
        checks++;
        if (a4_done !== 1'b0 || a4_prod !== exp_v) begin
            errors++;
            $display("FAIL %s_hold: done=%b product=0x%02h, required done=0 product=0x%02h",
                     name, a4_done, a4_prod, exp_v);
        end
    endtask

    task automatic test_reset();
        a4_start = 1'b0; a4_sm = 1'b0; a4_a = '0; a4_b = '0;
        u4_start = 1'b0; u4_sm = 1'b0; u4_a = '0; u4_b = '0;
        w8_start = 1'b0; w8_sm = 1'b0; w8_a = '0; w8_b = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a4_busy !== 1'b0 || a4_done !== 1'b0 || a4_prod !== 8'h00) begin
            errors++;
            $display("FAIL reset_a4: busy=%b done=%b product=0x%02h, required 0 0 0x00",
                     a4_busy, a4_done, a4_prod);
        end
        checks++;
        if (w8_busy !== 1'b0 || w8_done !== 1'b0 || w8_prod !== 16'h0000) begin
            errors++;
            $display("FAIL reset_w8: busy=%b done=%b product=0x%04h, required 0 0 0x0000",
                     w8_busy, w8_done, w8_prod);
        end
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        op4(4'd6,  4'd3,  1'b0, 8'd18,  "u_6x3");
        op4(4'd15, 4'd15, 1'b0, 8'd225, "u_15x15");
        op4(4'd0,  4'd12, 1'b0, 8'd0,   "u_0x12");
        op4(4'd15, 4'd1,  1'b0, 8'd15,  "u_15x1");
        op4(4'd1,  4'd15, 1'b0, 8'd15,  "u_1x15");
    endtask

    task automatic test_signed();
        op4(4'b1000, 4'b1000, 1'b1, 8'h40, "s_m8xm8");
        op4(4'b1101, 4'd5,    1'b1, 8'hF1, "s_m3x5");
        op4(4'd7,    4'b1111, 1'b1, 8'hF9, "s_7xm1");
        op4(4'd0,    4'b1011, 1'b1, 8'h00, "s_0xm5");
    endtask

    task automatic test_signed_disabled();
        int n;
        logic [7:0] exp_v;
        @(negedge clk);
        u4_a = 4'd15; u4_b = 4'd15; u4_sm = 1'b1; u4_start = 1'b1;
        q_u4.push_back(8'd225);
        @(negedge clk);
        u4_start = 1'b0;
        n = 0;
        while (u4_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp_v = q_u4.pop_front();
        checks++;
        if (u4_done !== 1'b1 || n !== 4 || u4_prod !== exp_v) begin
            errors++;
            $display("FAIL signed_disabled: done=%b edges=%0d product=%0d, required 1 4 %0d",
                     u4_done, n, u4_prod, exp_v);
        end
    endtask

    task automatic test_ignore_midrun();
        int pulses;
        int first_n;
        logic [7:0] at_done;
        logic [7:0] exp_v;
        @(negedge clk);
        a4_a = 4'd6; a4_b = 4'd3; a4_sm = 1'b0; a4_start = 1'b1;
        q_a4.push_back(8'd18);
        @(negedge clk);
        a4_start = 1'b0;
        pulses = 0;
        first_n = -1;
        at_done = '0;
        for (int n = 0; n < 16; n++) begin
            if (n == 1) begin
                a4_a = 4'd9; a4_b = 4'd9; a4_sm = 1'b1; a4_start = 1'b1;
            end else begin
                a4_start = 1'b0;
            end
            if (a4_done === 1'b1) begin
                pulses++;
                if (first_n < 0) begin
                    first_n = n;
                    at_done = a4_prod;
                end
            end
            @(negedge clk);
        end
        exp_v = q_a4.pop_front();
        checks++;
        if (pulses !== 1 || first_n !== 4) begin
            errors++;
            $display("FAIL midrun_pulses: %0d done pulses first at edge %0d, required 1 at 4",
                     pulses, first_n);
        end
        checks++;
        if (at_done !== exp_v) begin
            errors++;
            $display("FAIL midrun_product: got %0d, required %0d", at_done, exp_v);
        end
    endtask

    task automatic test_abort_reset();
        int pulses;
        @(negedge clk);
        a4_a = 4'd5; a4_b = 4'd5; a4_sm = 1'b0; a4_start = 1'b1;
        @(negedge clk);
        a4_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a4_busy !== 1'b0 || a4_done !== 1'b0 || a4_prod !== 8'h00) begin
            errors++;
            $display("FAIL abort_immediate: busy=%b done=%b product=0x%02h, required 0 0 0x00",
                     a4_busy, a4_done, a4_prod);
        end
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b1;
            if (a4_done === 1'b1 || a4_busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", pulses);
        end
        op4(4'd3, 4'd3, 1'b0, 8'd9, "after_abort_3x3");
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        int low;
        logic [15:0] exp_v;
        @(negedge clk);
        w8_a = 8'd255; w8_b = 8'd255; w8_sm = 1'b0; w8_start = 1'b1;
        q_w8.push_back(16'd65025);
        @(negedge clk);
        w8_start = 1'b0;
        n = 0;
        while (w8_done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        exp_v = q_w8.pop_front();
        checks++;
        if (w8_done !== 1'b1 || n !== 8 || w8_prod !== exp_v) begin
            errors++;
            $display("FAIL b2b_first: done=%b edges=%0d product=%0d, required 1 8 %0d",
                     w8_done, n, w8_prod, exp_v);
        end
        // Request the next operation while DONE is showing.
        w8_a = 8'd2; w8_b = 8'd3; w8_sm = 1'b0; w8_start = 1'b1;
        q_w8.push_back(16'd6);
        @(negedge clk);
        w8_start = 1'b0;
        m = 1;
        low = 0;
        while (w8_done !== 1'b1 && m < 40) begin
            low++;
            @(negedge clk);
            m++;
        end
        exp_v = q_w8.pop_front();
        checks++;
        if (w8_done !== 1'b1 || m !== 9) begin
            errors++;
            $display("FAIL b2b_spacing: second done %0d edges after first, required 9", m);
        end
        checks++;
        if (low !== 8) begin
            errors++;
            $display("FAIL b2b_gap: %0d low done cycles between pulses, required 8", low);
        end
        checks++;
        if (w8_prod !== exp_v) begin
            errors++;
            $display("FAIL b2b_second: got %0d, required %0d", w8_prod, exp_v);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        for (int i = 0; i < 8; i++) begin
            a  = 4'($urandom);
            b  = 4'($urandom);
            sm = 1'($urandom);
            op4(a, b, sm, model4(a, b, sm), "random");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_signed_disabled();
        test_ignore_midrun();
        test_abort_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult
